// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data width, default reset PC, fetch state encoding
// and opcode field constants used by the fetch unit, the control unit and benches.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  // opcode[6:2] values of the base integer ISA
  localparam logic [4:0] OP_IMM = 5'b00100;
  localparam logic [4:0] LOAD   = 5'b00000;
  localparam logic [4:0] STORE  = 5'b01000;

  typedef struct packed {
    logic [XLEN-1:0] word;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // A 32-bit encoding always has its two lowest bits set
  function automatic logic is_rv32(input logic [XLEN-1:0] word);
    return word[1:0] == 2'b11;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry buffer of fetched {word, pc} pairs between instruction memory
// and the control unit. Flush is synchronous and empties the buffer.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            push,
  input  logic [XLEN-1:0] push_word,
  input  logic [XLEN-1:0] push_pc,
  input  logic            pop,
  output logic [XLEN-1:0] head_word,
  output logic [XLEN-1:0] head_pc,
  output logic            full,
  output logic            empty
);

  fetch_entry_t mem_q [2];
  fetch_entry_t mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  assign full      = (count_q == 2'(DEPTH));
  assign empty     = (count_q == 2'd0);
  assign head_word = mem_q[rd_ptr_q].word;
  assign head_pc   = mem_q[rd_ptr_q].pc;

  // Next pointers, occupancy and storage; flush wins over push and pop
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      do_push = push && !full;
      do_pop  = pop && !empty;
      if (do_push) begin
        mem_d[wr_ptr_q] = '{word: push_word, pc: push_pc};
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Buffer registers; entries reset so the head reads as a zero word at RESET_PC
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '{word: '0, pc: RESET_PC};
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the fetch PC, issues word reads over a req/ack
// handshake, buffers returned words and hands them to the control unit.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fault
);

  fetch_state_e state_q, state_d;
  logic         squash_q, squash_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         req_q, req_d;
  logic [31:0]  addr_q, addr_d;
  logic         fault_q, fault_d;

  logic         ack_v;
  logic         redirect_bad;
  logic         hold_for_ack;
  logic         fifo_push, fifo_pop, fifo_flush;
  logic         fifo_full, fifo_empty;
  logic [31:0]  head_word, head_pc;

  // An ack only counts while a request is actually outstanding
  assign ack_v        = imem_ack && req_q;
  assign redirect_bad = (redirect_pc[1:0] != 2'b00);
  assign hold_for_ack = (state_q == WAIT) && !ack_v;

  fetch_fifo #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_word (imem_rdata),
    .push_pc   (addr_q),
    .pop       (fifo_pop),
    .head_word (head_word),
    .head_pc   (head_pc),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      squash_q   <= 1'b0;
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      squash_q   <= squash_d;
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      fault_q    <= fault_d;
    end
  end

  // Next state; redirect overrides everything, a live request is squashed rather than dropped
  always_comb begin
    state_d  = state_q;
    squash_d = squash_q;
    if (redirect) begin
      if (hold_for_ack) begin
        state_d  = WAIT;
        squash_d = 1'b1;
      end else begin
        state_d  = redirect_bad ? FAULT : IDLE;
        squash_d = 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_full) begin
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (ack_v) begin
            squash_d = 1'b0;
            if (squash_q) begin
              state_d = fault_q ? FAULT : IDLE;
            end else begin
              state_d = is_rv32(imem_rdata) ? IDLE : FAULT;
            end
          end
        end
        FAULT:   state_d = FAULT;
        default: state_d = IDLE;
      endcase
    end
  end

  // Request, address, fetch PC and fault updates that accompany each transition
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    fault_d    = fault_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      fault_d    = redirect_bad;
      req_d      = hold_for_ack;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_full) begin
            req_d  = 1'b1;
            addr_d = fetch_pc_q;
          end
        end
        WAIT: begin
          if (ack_v) begin
            req_d = 1'b0;
            if (!squash_q) begin
              fetch_pc_d = fetch_pc_q + 32'd4;
              if (!is_rv32(imem_rdata)) begin
                fault_d = 1'b1;
              end
            end
          end
        end
        default: begin
          req_d = 1'b0;
        end
      endcase
    end
  end

  // Buffer control and port outputs
  always_comb begin
    fifo_flush  = redirect;
    fifo_push   = !redirect && (state_q == WAIT) && ack_v && !squash_q && is_rv32(imem_rdata);
    fifo_pop    = !redirect && !fifo_empty && instr_ready;
    imem_req    = req_q;
    imem_addr   = addr_q;
    fault       = fault_q;
    instr_valid = !fifo_empty;
    instruction = head_word;
    pc          = head_pc;
  end

endmodule
